// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store sequencer that fronts the word-wide Memoria.
package mem_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } mem_op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } mau_state_t;

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] addr_lo);
        logic bad;
        case (op)
            LW, SW:       bad = (addr_lo != 2'b00);
            LH, LHU, SH:  bad = addr_lo[0];
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic is_load(input mem_op_t op);
        return op inside {LW, LH, LHU, LB, LBU};
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Datapath request/response and Memoria bus of the load/store sequencer.
interface mem_access_unit_if;
    import mem_pkg::*;

    logic        req;
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // The sequencer sits between datapath and memory, so it is the slave on both sides.
    modport slave (
        input  req, op, addr, wdata, mem_rdata,
        output busy, done, err, rdata, mem_addr, mem_wr, mem_wdata
    );

    modport master (
        output req, op, addr, wdata, mem_rdata,
        input  busy, done, err, rdata, mem_addr, mem_wr, mem_wdata
    );

endinterface

// File: rtl/mem_access_unit_byte_lane_unit.sv
// Little-endian lane handling: extract+extend for loads, lane merge for sub-word stores.
module byte_lane_unit
    import mem_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfwords are aligned here, so addr_lo[1] alone picks the upper or lower half.
    assign byte_v = word[{addr_lo, 3'b000} +: 8];
    assign half_v = word[{addr_lo[1], 4'b0000} +: 16];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        load_data = word;
        case (op)
            LB:      load_data = {{24{byte_v[7]}}, byte_v};
            LBU:     load_data = {24'h000000, byte_v};
            LH:      load_data = {{16{half_v[15]}}, half_v};
            LHU:     load_data = {16'h0000, half_v};
            default: load_data = word;
        endcase
    end

    always_comb begin
        store_word = word;
        case (op)
            SB:      store_word[{addr_lo, 3'b000} +: 8]      = wdata[7:0];
            SH:      store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            SW:      store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one request at a time, read-modify-write for sub-word stores,
// misaligned requests reported as an address exception without touching memory.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic               clock,
    input  logic               reset,
    mem_access_unit_if.slave   bus,
    output logic [2:0]         state_out
);

    localparam int CW = $clog2(MEM_LAT + 1);

    mau_state_t     state_q, state_d;
    mem_op_t        op_q, op_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    word_q, word_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    mem_wdata_q, mem_wdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           mem_wr_q, mem_wr_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic [31:0]    word_sel;
    logic [31:0]    lane_load;
    logic [31:0]    lane_store;

    // While waiting, the lane unit looks at the live memory word so the
    // extended load and the merged store word are ready on the capture edge.
    assign word_sel = (state_q == RD_WAIT) ? bus.mem_rdata : word_q;

    byte_lane_unit u_lanes (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .word       (word_sel),
        .wdata      (wdata_q),
        .load_data  (lane_load),
        .store_word (lane_store)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        rdata_d     = rdata_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        mem_wr_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    op_d    = bus.op;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (is_misaligned(bus.op, bus.addr[1:0])) begin
                        state_d = ERR;
                    end else if (bus.op == SW) begin
                        state_d     = WRITE;
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = bus.wdata;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = CW'(MEM_LAT);
                    end
                end
            end

            // The address first appears after the accepting edge, so data is
            // valid MEM_LAT edges later; capture happens once the count hits zero.
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    word_d = bus.mem_rdata;
                    if (is_load(op_q)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        rdata_d = lane_load;
                    end else begin
                        state_d     = WRITE;
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = lane_store;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            WRITE: begin
                state_d = DONE;
                done_d  = 1'b1;
            end

            // Exception is reported through the common completion cycle.
            ERR: begin
                state_d = DONE;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= LW;
            addr_q      <= '0;
            wdata_q     <= '0;
            word_q      <= '0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
            mem_wr_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            rdata_q     <= rdata_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            mem_wr_q    <= mem_wr_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with MEM_LAT=1 and MEM_LAT=3 instances and word memory models.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_access_unit_if bus1 ();
    mem_access_unit_if bus3 ();
    logic [2:0] state1;
    logic [2:0] state3;

    mem_access_unit #(.MEM_LAT(1)) u_dut1 (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus1),
        .state_out (state1)
    );

    mem_access_unit #(.MEM_LAT(3)) u_dut3 (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus3),
        .state_out (state3)
    );

    // Memory models: read data valid MEM_LAT edges after the address is driven.
    logic [31:0] mem1 [0:63];
    logic [31:0] mem3 [0:63];
    logic [31:0] rd1;
    logic [31:0] rd3 [0:2];

    always @(posedge clock) begin
        rd1 <= mem1[bus1.mem_addr[7:2]];
        if (bus1.mem_wr) mem1[bus1.mem_addr[7:2]] = bus1.mem_wdata;
    end

    always @(posedge clock) begin
        rd3[0] <= mem3[bus3.mem_addr[7:2]];
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
        if (bus3.mem_wr) mem3[bus3.mem_addr[7:2]] = bus3.mem_wdata;
    end

    assign bus1.mem_rdata = rd1;
    assign bus3.mem_rdata = rd3[2];

    int checks   = 0;
    int failures = 0;
    int wr1      = 0;
    int wr3      = 0;
    int done1    = 0;
    int done3    = 0;
    logic [31:0] last_wd1 = '0;

    always @(negedge clock) begin
        if (bus1.mem_wr) begin
            wr1++;
            last_wd1 = bus1.mem_wdata;
        end
        if (bus3.mem_wr) wr3++;
        if (bus1.done) done1++;
        if (bus3.done) done3++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue1(input mem_op_t op, input logic [31:0] a, input logic [31:0] w);
        bus1.req = 1'b1; bus1.op = op; bus1.addr = a; bus1.wdata = w;
        tick();
        bus1.req = 1'b0;
    endtask

    task automatic issue3(input mem_op_t op, input logic [31:0] a, input logic [31:0] w);
        bus3.req = 1'b1; bus3.op = op; bus3.addr = a; bus3.wdata = w;
        tick();
        bus3.req = 1'b0;
    endtask

    // Called right after edge 0; returns just after edge n with done expected high.
    task automatic wait_done1(input string tag, input int n);
        check1({tag, "_early"}, bus1.done, 1'b0);
        for (int i = 1; i < n; i++) begin
            tick();
            check1({tag, "_early"}, bus1.done, 1'b0);
        end
        tick();
        check1({tag, "_done"}, bus1.done, 1'b1);
    endtask

    task automatic wait_done3(input string tag, input int n);
        check1({tag, "_early"}, bus3.done, 1'b0);
        for (int i = 1; i < n; i++) begin
            tick();
            check1({tag, "_early"}, bus3.done, 1'b0);
        end
        tick();
        check1({tag, "_done"}, bus3.done, 1'b1);
    endtask

    task automatic load1(input string tag, input mem_op_t op, input logic [31:0] a, input logic [31:0] exp);
        issue1(op, a, 32'h0);
        wait_done1(tag, 2);
        check({tag, "_rdata"}, bus1.rdata, exp);
        check1({tag, "_err"}, bus1.err, 1'b0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before the directed sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        bus1.req = 1'b0; bus1.op = LW; bus1.addr = '0; bus1.wdata = '0;
        bus3.req = 1'b0; bus3.op = LW; bus3.addr = '0; bus3.wdata = '0;
        for (int i = 0; i < 64; i++) begin
            mem1[i] = '0;
            mem3[i] = '0;
        end

        // Reset values
        #2;
        check1("rst_busy", bus1.busy, 1'b0);
        check1("rst_done", bus1.done, 1'b0);
        check1("rst_err", bus1.err, 1'b0);
        check("rst_rdata", bus1.rdata, 32'h0);
        check("rst_mem_addr", bus1.mem_addr, 32'h0);
        check1("rst_mem_wr", bus1.mem_wr, 1'b0);
        check("rst_mem_wdata", bus1.mem_wdata, 32'h0);
        check("rst_state", 32'(state1), 32'(IDLE));
        check1("rst_busy3", bus3.busy, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // LW, MEM_LAT=1: done after edge 2
        mem1[4] = 32'h8899AABB;
        issue1(LW, 32'h10, 32'h0);
        check1("lw_busy", bus1.busy, 1'b1);
        check("lw_mem_addr", bus1.mem_addr, 32'h10);
        wait_done1("lw", 2);
        check("lw_rdata", bus1.rdata, 32'h8899AABB);
        check1("lw_err", bus1.err, 1'b0);
        check("lw_mem_addr_held", bus1.mem_addr, 32'h10);

        // req during the DONE cycle is dropped
        bus1.req = 1'b1; bus1.op = LW; bus1.addr = 32'h10;
        tick();
        bus1.req = 1'b0;
        check1("done_req_ignored_busy", bus1.busy, 1'b0);
        check("done_req_ignored_state", 32'(state1), 32'(IDLE));

        // Sub-word loads, each issued in the IDLE cycle right after DONE
        mem1[4] = 32'h80112233;
        load1("lb_13", LB, 32'h13, 32'hFFFFFF80);
        load1("lbu_13", LBU, 32'h13, 32'h00000080);
        load1("lh_12", LH, 32'h12, 32'hFFFF8011);
        load1("lhu_12", LHU, 32'h12, 32'h00008011);
        load1("lb_10", LB, 32'h10, 32'h00000033);
        load1("lb_11", LB, 32'h11, 32'h00000022);

        // SB read-modify-write: done after edge 3, one write
        mem1[8] = 32'h11223344;
        w0 = wr1;
        issue1(SB, 32'h21, 32'h000000CC);
        wait_done1("sb", 3);
        check("sb_wr_count", 32'(wr1 - w0), 32'd1);
        check("sb_wdata", last_wd1, 32'h1122CC44);
        check("sb_mem", mem1[8], 32'h1122CC44);
        tick();

        // SW: mem_wr in cycle 1, done after edge 1
        w0 = wr1;
        issue1(SW, 32'h24, 32'hDEADBEEF);
        check1("sw_mem_wr", bus1.mem_wr, 1'b1);
        check("sw_mem_wdata", bus1.mem_wdata, 32'hDEADBEEF);
        check("sw_mem_addr", bus1.mem_addr, 32'h24);
        wait_done1("sw", 1);
        check1("sw_mem_wr_low", bus1.mem_wr, 1'b0);
        tick();
        check("sw_mem", mem1[9], 32'hDEADBEEF);
        check("sw_wr_count", 32'(wr1 - w0), 32'd1);

        // SH into the upper half of the word just written by SB
        issue1(SH, 32'h22, 32'h1234ABCD);
        wait_done1("sh", 3);
        tick();
        check("sh_mem", mem1[8], 32'hABCDCC44);

        // Misaligned: done+err after edge 1, no write, rdata held
        w0 = wr1;
        issue1(LW, 32'h06, 32'h0);
        wait_done1("lw_mis", 1);
        check1("lw_mis_err", bus1.err, 1'b1);
        check("lw_mis_rdata", bus1.rdata, 32'h00000022);
        tick();
        check1("lw_mis_err_clr", bus1.err, 1'b0);
        issue1(SH, 32'h05, 32'h0000FFFF);
        wait_done1("sh_mis", 1);
        check1("sh_mis_err", bus1.err, 1'b1);
        tick();
        check("mis_wr_count", 32'(wr1 - w0), 32'd0);
        check("mis_rdata", bus1.rdata, 32'h00000022);
        check("mis_mem", mem1[1], 32'h0);

        // MEM_LAT=3: req held for edges 0..5 gives exactly one access
        mem3[4] = 32'hCAFEF00D;
        d0 = done3;
        bus3.req = 1'b1; bus3.op = LW; bus3.addr = 32'h10; bus3.wdata = '0;
        for (int i = 0; i < 4; i++) tick();
        check1("hold_done_early", bus3.done, 1'b0);
        tick();
        check1("hold_done_edge4", bus3.done, 1'b1);
        check("hold_rdata", bus3.rdata, 32'hCAFEF00D);
        tick();
        bus3.req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("hold_done_count", 32'(done3 - d0), 32'd1);
        check1("hold_idle", bus3.busy, 1'b0);
        check("hold_no_write", 32'(wr3), 32'd0);

        mem3[5] = 32'h01020304;
        issue3(LW, 32'h14, 32'h0);
        wait_done3("lw3", 4);
        check("lw3_rdata", bus3.rdata, 32'h01020304);
        tick();

        // Reset while an SH sits in RD_WAIT
        w0 = wr1;
        d0 = done1;
        issue1(SH, 32'h22, 32'h00005555);
        check("rstmid_state_before", 32'(state1), 32'(RD_WAIT));
        #2;
        reset = 1'b1;
        #1;
        check1("rstmid_busy", bus1.busy, 1'b0);
        check1("rstmid_done", bus1.done, 1'b0);
        check1("rstmid_err", bus1.err, 1'b0);
        check("rstmid_rdata", bus1.rdata, 32'h0);
        check("rstmid_mem_addr", bus1.mem_addr, 32'h0);
        check1("rstmid_mem_wr", bus1.mem_wr, 1'b0);
        check("rstmid_mem_wdata", bus1.mem_wdata, 32'h0);
        check("rstmid_state", 32'(state1), 32'(IDLE));
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("rstmid_wr_count", 32'(wr1 - w0), 32'd0);
        check("rstmid_done_count", 32'(done1 - d0), 32'd0);
        check("rstmid_mem", mem1[8], 32'hABCDCC44);

        load1("post_rst_lw", LW, 32'h20, 32'hABCDCC44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
